// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 access-size codes, FSM state
// encoding and the store byte-enable helper.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Access-size decode; the reserved codes 011/110/111 behave as a word.
    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Byte-lane enables for a store of the given size at the given low address bits.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b1111;
        if (is_byte(f3)) begin
            be = 4'b0001 << lo;
        end else if (is_half(f3)) begin
            be = lo[1] ? 4'b1100 : 4'b0011;
        end
        return be;
    endfunction

endpackage

// File: rtl/data_mem_bytelane.sv
// DEPTH x XLEN data memory: synchronous per-byte write, combinational read.
// Contents are deliberately not reset.
module data_mem_bytelane #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                      clk,
    input  logic [$clog2(DEPTH)-1:0]  addr_i,
    input  logic [XLEN/8-1:0]         we_i,
    input  logic [XLEN-1:0]           wdata_i,
    output logic [XLEN-1:0]           rdata_o
);

    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] mem_q [DEPTH];

    // Byte-lane write port
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(NB); b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Asynchronous read port
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: byte/half/word loads and stores with
// sign/zero extension, optional multi-cycle access latency with a ready
// stall, and a registered one-cycle completion pulse towards WB.
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses instead of masking the low address bits.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ACCESS_LAT = 0
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [2:0]      mem_funct3,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_reg_write,
    input  logic            mem_mem_read,
    input  logic            mem_mem_write,
    input  logic            mem_mem_to_reg,
    output logic            wb_valid,
    output logic [XLEN-1:0] mem_wb_data,
    output logic [XLEN-1:0] mem_wb_alu,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic            wb_misalign
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned CW = 3;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;

    logic [XLEN-1:0] addr_q, data_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            rw_q, rd_en_q, wr_q, m2r_q;

    logic            accept_c, done_c, misalign_c, load_c;
    logic [1:0]      lo_c;
    logic [NB-1:0]   we_c;
    logic [XLEN-1:0] wdata_c, rdata_c, ld_ext_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;

    assign accept_c = mem_valid & mem_ready;
    assign done_c   = pend_q;

    // FSM state register, wait counter and completion-pending flag
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next state: memory ops wait ACCESS_LAT cycles, then complete on the following edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if ((mem_mem_read || mem_mem_write) && (ACCESS_LAT != 0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(ACCESS_LAT);
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_ready = 1'b0;
        if (state_q == ST_IDLE) begin
            mem_ready = 1'b1;
        end
    end

    // Request latch, loaded on every accepted handshake
    always_ff @(posedge clk) begin
        if (rst_) begin
            addr_q  <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            rd_en_q <= 1'b0;
            wr_q    <= 1'b0;
            m2r_q   <= 1'b0;
        end else if (accept_c) begin
            addr_q  <= mem_alu_result;
            data_q  <= mem_data;
            f3_q    <= mem_funct3;
            rd_q    <= mem_rd_addr;
            rw_q    <= mem_reg_write;
            rd_en_q <= mem_mem_read;
            wr_q    <= mem_mem_write;
            m2r_q   <= mem_mem_to_reg;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned half/word memory accesses are flagged; low bits kept as-is
    always_comb begin
        lo_c       = addr_q[1:0];
        misalign_c = (rd_en_q | wr_q) &
                     ((is_half(f3_q) & addr_q[0]) |
                      (!is_byte(f3_q) & !is_half(f3_q) & (addr_q[1:0] != 2'b00)));
    end
`else
    // Low address bits below the access size are masked off
    always_comb begin
        lo_c       = addr_q[1:0];
        misalign_c = 1'b0;
        if (is_half(f3_q)) begin
            lo_c = {addr_q[1], 1'b0};
        end else if (!is_byte(f3_q)) begin
            lo_c = 2'b00;
        end
    end
`endif

    // Store lane data and enables, committed on the completion edge
    always_comb begin
        wdata_c = data_q;
        if (is_byte(f3_q)) begin
            wdata_c = {NB{data_q[7:0]}};
        end else if (is_half(f3_q)) begin
            wdata_c = {(NB/2){data_q[15:0]}};
        end
        we_c = '0;
        if (done_c && wr_q && !misalign_c) begin
            we_c = NB'(byte_en(f3_q, lo_c));
        end
    end

    data_mem_bytelane #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk     (clk),
        .addr_i  (addr_q[AW+1:2]),
        .we_i    (we_c),
        .wdata_i (wdata_c),
        .rdata_o (rdata_c)
    );

    // Load lane extraction and sign/zero extension
    always_comb begin
        byte_c   = 8'(rdata_c >> {lo_c, 3'b000});
        half_c   = 16'(rdata_c >> {lo_c[1], 4'b0000});
        ld_ext_c = rdata_c;
        if (is_byte(f3_q)) begin
            ld_ext_c = (f3_q == F3_BU) ? XLEN'(byte_c) : {{(XLEN-8){byte_c[7]}}, byte_c};
        end else if (is_half(f3_q)) begin
            ld_ext_c = (f3_q == F3_HU) ? XLEN'(half_c) : {{(XLEN-16){half_c[15]}}, half_c};
        end
        load_c = rd_en_q & ~wr_q & ~misalign_c;
    end

    // MEM/WB register: one-cycle completion pulse, payload held between completions
    always_ff @(posedge clk) begin
        if (rst_) begin
            wb_valid      <= 1'b0;
            mem_wb_data   <= '0;
            mem_wb_alu    <= '0;
            wb_rd_addr    <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_misalign   <= 1'b0;
        end else begin
            wb_valid      <= done_c;
            wb_reg_write  <= done_c & rw_q & ~misalign_c;
            wb_mem_to_reg <= done_c & m2r_q;
            wb_misalign   <= done_c & misalign_c;
            if (done_c) begin
                mem_wb_data <= load_c ? ld_ext_c : '0;
                mem_wb_alu  <= addr_q;
                wb_rd_addr  <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (ACCESS_LAT=2, DEPTH=256).
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-access vectors.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned LAT  = 2;

    logic            clk = 1'b0;
    logic            rst_;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_alu_result, mem_data;
    logic [2:0]      mem_funct3;
    logic [4:0]      mem_rd_addr;
    logic            mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic            wb_valid;
    logic [XLEN-1:0] mem_wb_data, mem_wb_alu;
    logic [4:0]      wb_rd_addr;
    logic            wb_reg_write, wb_mem_to_reg, wb_misalign;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(
        .XLEN       (XLEN),
        .DEPTH      (256),
        .ACCESS_LAT (LAT)
    ) dut (
        .clk            (clk),
        .rst_           (rst_),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_alu_result (mem_alu_result),
        .mem_data       (mem_data),
        .mem_funct3     (mem_funct3),
        .mem_rd_addr    (mem_rd_addr),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .wb_valid       (wb_valid),
        .mem_wb_data    (mem_wb_data),
        .mem_wb_alu     (mem_wb_alu),
        .wb_rd_addr     (wb_rd_addr),
        .wb_reg_write   (wb_reg_write),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_misalign    (wb_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd_en;
        logic        wr;
        logic        rw;
        logic        m2r;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rdst;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rd_en, input logic wr,
                                input logic rw, input logic m2r, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [4:0] rdst, input logic [31:0] exp_data,
                                input logic exp_rw, input logic exp_mis);
        vec_t v;
        v.name = name; v.rd_en = rd_en; v.wr = wr; v.rw = rw; v.m2r = m2r;
        v.f3 = f3; v.addr = addr; v.data = data; v.rdst = rdst;
        v.exp_data = exp_data; v.exp_rw = exp_rw; v.exp_mis = exp_mis;
        return v;
    endfunction

    // Issue one instruction, wait for its completion, check payload and timing
    task automatic run_vec(input vec_t v);
        int lat;
        int low;
        bit got;
        int exp_lat;
        exp_lat = (v.rd_en || v.wr) ? int'(LAT) + 1 : 1;
        mem_alu_result = v.addr; mem_data = v.data; mem_funct3 = v.f3;
        mem_rd_addr = v.rdst; mem_reg_write = v.rw; mem_mem_read = v.rd_en;
        mem_mem_write = v.wr; mem_mem_to_reg = v.m2r; mem_valid = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        lat = 0; low = 0; got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!mem_ready) low++;
            @(posedge clk); #1;
            lat++;
            if (wb_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({v.name, "_wb_seen"}, 32'(got), 32'd1);
        chk({v.name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({v.name, "_ready_low"}, 32'(low), 32'(exp_lat - 1));
        chk({v.name, "_data"}, mem_wb_data, v.exp_data);
        chk({v.name, "_alu"}, mem_wb_alu, v.addr);
        chk({v.name, "_rd"}, 32'(wb_rd_addr), 32'(v.rdst));
        chk({v.name, "_rw"}, 32'(wb_reg_write), 32'(v.exp_rw));
        chk({v.name, "_m2r"}, 32'(wb_mem_to_reg), 32'(v.m2r));
        chk({v.name, "_mis"}, 32'(wb_misalign), 32'(v.exp_mis));
    endtask

    initial begin
        bit saw;
        bit low;
        rst_ = 1'b1; mem_valid = 1'b0; mem_alu_result = '0; mem_data = '0;
        mem_funct3 = '0; mem_rd_addr = '0; mem_reg_write = 1'b0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_mem_to_reg = 1'b0;

        // Vector table: rd_en wr rw m2r f3 addr data rd | exp_data exp_rw exp_mis
        vecs.push_back(mk("sw_10",   0, 1, 0, 0, F3_W,  32'h10,  32'hDEADBEEF, 5'd0, 32'h0,        0, 0));
        vecs.push_back(mk("lw_10",   1, 0, 1, 1, F3_W,  32'h10,  32'h0,        5'd3, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk("sb_11",   0, 1, 0, 0, F3_B,  32'h11,  32'h00000080, 5'd0, 32'h0,        0, 0));
        vecs.push_back(mk("lb_11",   1, 0, 1, 1, F3_B,  32'h11,  32'h0,        5'd4, 32'hFFFFFF80, 1, 0));
        vecs.push_back(mk("lbu_11",  1, 0, 1, 1, F3_BU, 32'h11,  32'h0,        5'd4, 32'h00000080, 1, 0));
        vecs.push_back(mk("lw_10b",  1, 0, 1, 1, F3_W,  32'h10,  32'h0,        5'd3, 32'hDEAD80EF, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("lh_13",   1, 0, 1, 1, F3_H,  32'h13,  32'h0,        5'd6, 32'h0,        0, 1));
`else
        vecs.push_back(mk("lh_13",   1, 0, 1, 1, F3_H,  32'h13,  32'h0,        5'd6, 32'hFFFFDEAD, 1, 0));
`endif
        vecs.push_back(mk("sw_20",   0, 1, 0, 0, F3_W,  32'h20,  32'h11223344, 5'd0, 32'h0,        0, 0));
        vecs.push_back(mk("sw_400",  0, 1, 0, 0, F3_W,  32'h400, 32'hCAFEF00D, 5'd0, 32'h0,        0, 0));
        vecs.push_back(mk("lw_000",  1, 0, 1, 1, F3_W,  32'h0,   32'h0,        5'd8, 32'hCAFEF00D, 1, 0));
        vecs.push_back(mk("rdwr_24", 1, 1, 1, 1, F3_W,  32'h24,  32'hA5A5A5A5, 5'd9, 32'h0,        1, 0));
        vecs.push_back(mk("lw_24",   1, 0, 1, 1, F3_W,  32'h24,  32'h0,        5'd9, 32'hA5A5A5A5, 1, 0));
        vecs.push_back(mk("sh_26",   0, 1, 0, 0, F3_H,  32'h26,  32'hFFFFBEEF, 5'd0, 32'h0,        0, 0));
        vecs.push_back(mk("lhu_26",  1, 0, 1, 1, F3_HU, 32'h26,  32'h0,        5'd10, 32'h0000BEEF, 1, 0));
        vecs.push_back(mk("lh_24",   1, 0, 1, 1, F3_H,  32'h24,  32'h0,        5'd10, 32'hFFFFA5A5, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_27",   1, 0, 1, 1, F3_W,  32'h27,  32'h0,        5'd11, 32'h0,        0, 1));
`else
        vecs.push_back(mk("lw_27",   1, 0, 1, 1, F3_W,  32'h27,  32'h0,        5'd11, 32'hBEEFA5A5, 1, 0));
`endif
        vecs.push_back(mk("alu_op",  0, 0, 1, 0, F3_W,  32'hFFFF0001, 32'h0,   5'd7, 32'h0,        1, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(mem_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_data", mem_wb_data, 32'h0);
        chk("rst_alu", mem_wb_alu, 32'h0);
        chk("rst_ctrl", {24'h0, wb_rd_addr, wb_reg_write, wb_mem_to_reg, wb_misalign}, 32'h0);
        rst_ = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during WAIT abandons the store to 0x20
        mem_alu_result = 32'h20; mem_data = 32'h0; mem_funct3 = F3_W;
        mem_rd_addr = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
        mem_mem_write = 1'b1; mem_mem_to_reg = 1'b0; mem_valid = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        chk("midwait_ready_low", 32'(mem_ready), 32'd0);
        rst_ = 1'b1;
        @(posedge clk); #1;
        rst_ = 1'b0;
        chk("midwait_ready_after_rst", 32'(mem_ready), 32'd1);
        saw = 1'b0;
        if (wb_valid) saw = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (wb_valid) saw = 1'b1;
        end
        chk("midwait_no_wb", 32'(saw), 32'd0);
        run_vec(mk("lw_20", 1, 0, 1, 1, F3_W, 32'h20, 32'h0, 5'd12, 32'h11223344, 1, 0));

        // Three back-to-back ALU-only ops
        mem_alu_result = 32'h12345678; mem_data = 32'h0; mem_funct3 = F3_W;
        mem_rd_addr = 5'd5; mem_reg_write = 1'b1; mem_mem_read = 1'b0;
        mem_mem_write = 1'b0; mem_mem_to_reg = 1'b0; mem_valid = 1'b1;
        low = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_valid = 1'b0;
            if (!mem_ready) low = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("b2b_wb_valid_%0d", i), 32'(wb_valid), 32'd1);
            chk($sformatf("b2b_alu_%0d", i), mem_wb_alu, 32'h12345678);
            chk($sformatf("b2b_rd_%0d", i), 32'(wb_rd_addr), 32'd5);
            chk($sformatf("b2b_m2r_%0d", i), 32'(wb_mem_to_reg), 32'd0);
            chk($sformatf("b2b_rw_%0d", i), 32'(wb_reg_write), 32'd1);
        end
        chk("b2b_ready_never_low", 32'(low), 32'd0);
        @(posedge clk); #1;
        chk("b2b_wb_valid_end", 32'(wb_valid), 32'd0);
        chk("b2b_rw_end", 32'(wb_reg_write), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
